issue_execute_fifo: RTL
=======================

Name: issue_execute_fifo

Overview:
- Receiving end of the issue-to-execute handoff: one instance per execute unit (ALU/BRU/CSR/DIV/LSU/MUL).
- The issue stage pushes issue_execute_pack_t entries and watches full; the execute unit pops entries in order.
- Provides in-order buffering, occupancy reporting, single-cycle flush on pipeline redirect, and error pulses for illegal push/pop.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
issue_fifo_data_in  input  issue_execute_pack_t  entry from issue stage
issue_fifo_push  input  1  write request from issue stage
issue_fifo_flush  input  1  discard all entries (commit flush)
issue_fifo_full  output  1  count == DEPTH
execute_fifo_data_out  output  issue_execute_pack_t  head entry
execute_fifo_data_out_valid  output  1  head entry valid (count != 0)
execute_fifo_pop  input  1  execute unit consumes the head entry
fifo_count  output  CNT_WIDTH  current occupancy
fifo_overflow  output  1  one-cycle pulse: push attempted while full
fifo_underflow  output  1  one-cycle pulse: pop attempted while empty

Behaviour:
- Storage: DEPTH-entry array, write pointer wptr, read pointer rptr (log2(DEPTH) bits), and a count register.
- Pointers wrap DEPTH-1 -> 0 naturally.
- Reset (async, rst=1): wptr=0, rptr=0, count=0, fifo_overflow=0, fifo_underflow=0. Outputs during and after reset: issue_fifo_full=0, execute_fifo_data_out_valid=0, fifo_count=0. Storage contents are not reset.
- full, valid and fifo_count are derived combinationally from the registered count only. They do not depend on same-cycle push/pop.
- execute_fifo_data_out = mem[rptr], always driven. Its value is meaningful only when valid=1.
- Push accepted when push=1, full=0, flush=0: mem[wptr] <= data_in, wptr++.
- Pop accepted when pop=1, valid=0 is false (i.e. valid=1) and flush=0: rptr++.
- count next = count + push_acc - pop_acc.
- Latency: an entry pushed in cycle N appears on data_out with valid=1 in cycle N+1. There is no same-cycle bypass.
- Empty with push and pop in the same cycle: push accepted, pop rejected (fifo_underflow pulses). Count becomes 1.
- Full with push and pop in the same cycle: pop accepted, push rejected (fifo_overflow pulses). Count becomes DEPTH-1.
- Partially filled with push and pop in the same cycle: both accepted, count unchanged, both pointers advance.
- Flush: synchronous and highest priority. Next cycle wptr=rptr=0 and count=0. Push and pop in the flush cycle are ignored and raise no error pulses.
- fifo_overflow / fifo_underflow are registered pulses: asserted the cycle after the offending request, for exactly one cycle per offending request, cleared otherwise.
- Reset asserted mid-operation: all state clears immediately, independent of clk. Entries pushed before reset are not visible afterwards.
- Ordering: entries leave in strict push order. There is no reordering and no selective kill; partial squash is done by the execute unit using rob_id.

Test Plan:
- Reset then idle: hold rst=1 for 1 clk, release -> full=0, valid=0, count=0, overflow=0, underflow=0.
- Fill and drain with DEPTH=4:
  - Push rob_id 1,2,3,4 on consecutive cycles -> count 1,2,3,4, full=1 after the 4th push.
  - Pop 4 times -> data_out.rob_id 1,2,3,4 in order, valid drops and count=0 after the 4th pop.
- Overflow / simultaneous at full: at count=4, push rob_id 9 with no pop -> overflow pulses one cycle, count stays 4, head rob_id stays 1. Then push 9 with pop -> rob_id 1 leaves, 9 rejected, count=3.
- Empty push+pop: at count=0, push rob_id 5 with pop=1 -> underflow pulses, next cycle valid=1, data_out.rob_id=5, count=1.
- Wrap-around: 10 push/pop pairs at steady count=2 -> output rob_id sequence matches input exactly, count stays 2, no error pulses.
- Flush and async reset:
  - At count=3, flush=1 with push=1 -> next cycle count=0, valid=0, no overflow pulse. A following push of rob_id 7 appears at the head.
  - Assert rst between clock edges at count=2 -> count=0 and valid=0 before the next posedge.

Source files
------------

// File: rtl/issue_execute_fifo_if.sv
// rtl/issue_execute_fifo_if.sv - issue-to-execute entry type and FIFO handshake interface
package issue_execute_pkg;
   typedef struct packed {
      logic [5:0]  rob_id;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [31:0] src1;
      logic [31:0] src2;
   } issue_execute_pack_t;
endpackage

interface issue_execute_fifo_if #(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
);
   import issue_execute_pkg::*;

   issue_execute_pack_t  issue_fifo_data_in;
   logic                 issue_fifo_push;
   logic                 issue_fifo_flush;
   logic                 issue_fifo_full;
   issue_execute_pack_t  execute_fifo_data_out;
   logic                 execute_fifo_data_out_valid;
   logic                 execute_fifo_pop;
   logic [CNT_WIDTH-1:0] fifo_count;
   logic                 fifo_overflow;
   logic                 fifo_underflow;

   modport master (
      output issue_fifo_data_in, issue_fifo_push, issue_fifo_flush, execute_fifo_pop,
      input  issue_fifo_full, execute_fifo_data_out, execute_fifo_data_out_valid,
             fifo_count, fifo_overflow, fifo_underflow
   );

   modport slave (
      input  issue_fifo_data_in, issue_fifo_push, issue_fifo_flush, execute_fifo_pop,
      output issue_fifo_full, execute_fifo_data_out, execute_fifo_data_out_valid,
             fifo_count, fifo_overflow, fifo_underflow
   );
endinterface

// File: rtl/issue_execute_fifo.sv
// rtl/issue_execute_fifo.sv - in-order issue-to-execute buffer with flush and error pulses
module issue_execute_fifo
   import issue_execute_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input logic                  clk,
   input logic                  rst,
   issue_execute_fifo_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);

   issue_execute_pack_t  mem [DEPTH];
   logic [PTR_W-1:0]     wptr;
   logic [PTR_W-1:0]     rptr;
   logic [CNT_WIDTH-1:0] count;
   logic                 overflow_q;
   logic                 underflow_q;

   logic full;
   logic valid;
   logic push_acc;
   logic pop_acc;

   // Status comes from the registered count only, never from same-cycle requests.
   always_comb begin
      full     = (count == CNT_WIDTH'(DEPTH));
      valid    = (count != '0);
      push_acc = bus.issue_fifo_push  && !full  && !bus.issue_fifo_flush;
      pop_acc  = bus.execute_fifo_pop && valid  && !bus.issue_fifo_flush;
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wptr] <= bus.issue_fifo_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.issue_fifo_flush) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_acc) begin
            wptr <= wptr + PTR_W'(1);
         end
         if (pop_acc) begin
            rptr <= rptr + PTR_W'(1);
         end
         count       <= count + CNT_WIDTH'(push_acc) - CNT_WIDTH'(pop_acc);
         overflow_q  <= bus.issue_fifo_push  && full;
         underflow_q <= bus.execute_fifo_pop && !valid;
      end
   end

   always_comb begin
      bus.issue_fifo_full             = full;
      bus.execute_fifo_data_out_valid = valid;
      bus.execute_fifo_data_out       = mem[rptr];
      bus.fifo_count                  = count;
      bus.fifo_overflow               = overflow_q;
      bus.fifo_underflow              = underflow_q;
   end
endmodule
